pc_call_stack: RTL and testbench
================================

// Module: pc_call_stack
// PURPOSE
//  Parametrised program counter for the Ben computer datapath with jump, call and return.
//  Sequential fetch with configurable wrap, absolute jumps, and a hardware return-address stack.
//  Sits between the control unit (op, en) and instruction memory address (pc).
// PARAMETERS
//  WIDTH        32   PC and target width in bits
//  LAST         16   highest sequential PC; next sequential after LAST is 0 (LAST < 2**WIDTH)
//  STEP         1    sequential increment
//  STACK_DEPTH  4    return-address entries (>=1)
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        asynchronous, active-high reset
//  en           in   1        update enable; 0 = hold all state (stall)
//  op           in   2        00 SEQ, 01 JUMP, 10 CALL, 11 RET
//  target       in   WIDTH    jump/call destination (or signed offset, see CONFIGURATION)
//  rel          in   1        relative-target select (used only with PC_REL_BRANCH_EN)
//  pc           out  WIDTH    current program counter (registered)
//  stack_full   out  1        STACK_DEPTH entries held
//  stack_empty  out  1        zero entries held
//  err          out  1        sticky: overflow or underflow occurred since reset
// BEHAVIOUR
//  - Reset (async, rst=1): pc=0, stack pointer=0, err=0; stack_empty=1, stack_full=0.
//  - seq(pc) = (pc < LAST) ? pc+STEP : 0, computed in WIDTH bits (pc+STEP truncates).
//  - en=0: pc, stack, err unchanged regardless of op.
//  - en=1, updates on rising clk; new pc visible next cycle (1-cycle latency):
//    SEQ : pc <= seq(pc).
//    JUMP: pc <= tgt.
//    CALL: not full -> push seq(pc), pc <= tgt. Full -> pc <= tgt, push suppressed, err <= 1.
//    RET : not empty -> pc <= top, pop. Empty -> pc <= seq(pc), err <= 1.
//  - tgt = target unless relative mode active (see CONFIGURATION).
//  - Stack is LIFO; stack_full/stack_empty are decoded from registered pointer, same cycle as pc.
//  - err clears only on rst.
//  - rst asserted mid-operation overrides any pending op; stack contents need not clear,
//    pointer must.
// CONFIGURATION
//  PC_REL_BRANCH_EN defined: when rel=1 and op is JUMP or CALL, tgt = pc + target
//    (target two's complement, WIDTH-bit wrap); rel=0 gives absolute target.
//  PC_REL_BRANCH_EN undefined: rel ignored; tgt = target always.
// STRUCTURE
//  - Shared package pc_pkg: op encoding constants (PC_OP_SEQ/JUMP/CALL/RET), op typedef.
//  - Sub-module pc_ret_stack (WIDTH, STACK_DEPTH): push/pop/top, full/empty, pointer + array,
//    async reset of pointer; top module holds pc register, next-pc mux, err.
// TESTING
//  1. Reset then en=1 op=SEQ 20 cycles (LAST=16) -> pc 0,1..16,0,1,2,3; err=0.
//  2. pc=5, op=JUMP target=0x40 -> pc=0x40 next cycle; stack_empty stays 1.
//  3. pc=3, CALL 0x20 then RET -> pc=0x20 then 4; stack_empty 1->0->1.
//  4. DEPTH=4: 5 CALLs -> stack_full=1 after 4th, 5th still jumps, err=1;
//     5 RETs -> 4 return addrs in reverse order, 5th gives seq(pc).
//  5. en=0 with op=CALL for 3 cycles -> pc and stack_empty unchanged; rst pulse mid-cycle
//     -> pc=0 immediately, stack_empty=1, err=0.
//  6. PC_REL_BRANCH_EN: pc=0x10, rel=1, JUMP target=-4 -> pc=0x0C; undefined -> pc=0xFFFFFFFC.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program counter / return-stack block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: pc_op_t operation encoding (PC_OP_SEQ/JUMP/CALL/RET).
package pc_pkg;

  // Control-unit operation codes driven on pc_call_stack.op
  typedef enum logic [1:0] {
    PC_OP_SEQ  = 2'b00,
    PC_OP_JUMP = 2'b01,
    PC_OP_CALL = 2'b10,
    PC_OP_RET  = 2'b11
  } pc_op_t;

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO of return addresses with full/empty decoded from a registered entry count.
// Latency: push/pop take effect on the next rising clk; top is combinational from state.
// Backpressure: push while full and pop while empty are ignored (caller flags the error).
// Ports: clk, rst (async active-high, clears count only), push/push_data, pop,
//        top (most recent entry, 0 when empty), full, empty.
module pc_ret_stack #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  // Count needs to represent 0..STACK_DEPTH; index covers 0..STACK_DEPTH-1.
  localparam int unsigned PTR_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PTR_W-1:0] cnt;
  logic [WIDTH-1:0] mem [STACK_DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == PTR_W'(STACK_DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next free slot is at cnt; the newest entry sits one below it.
  assign wr_idx  = IDX_W'(cnt);
  assign top_idx = IDX_W'(cnt - PTR_W'(1));
  assign top     = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (do_push) begin
      cnt <= cnt + PTR_W'(1);
    end else if (do_pop) begin
      cnt <= cnt - PTR_W'(1);
    end
  end

  // Entry storage is not reset: only the count defines what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with sequential fetch (wrap after LAST), jump, call and return.
// Latency: one cycle from op (with en=1) to the new pc; stack flags update with pc.
// Backpressure: en=0 stalls everything; call-on-full / return-on-empty set sticky err.
// Ports: clk, rst (async active-high), en, op (pc_op_t), target, rel,
//        pc, stack_full, stack_empty, err.
// Option: define PC_REL_BRANCH_EN to let rel=1 make JUMP/CALL targets pc-relative.
module pc_call_stack
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned LAST        = 16,
  parameter int unsigned STEP        = 1,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] target,
  input  logic             rel,
  output logic [WIDTH-1:0] pc,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             err
);

  localparam logic [WIDTH-1:0] LAST_W = WIDTH'(LAST);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  pc_op_t           op_q;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] stk_top;
  logic             push;
  logic             pop;
  logic             err_set;

  assign op_q = pc_op_t'(op);

  // pc + STEP truncates to WIDTH bits; anything above LAST wraps to 0.
  assign seq_pc = (pc < LAST_W) ? (pc + STEP_W) : '0;

`ifdef PC_REL_BRANCH_EN
  // target is a two's-complement offset when rel=1; plain add wraps in WIDTH bits.
  assign tgt = rel ? (pc + target) : target;
`else
  logic unused_rel;
  assign unused_rel = rel;
  assign tgt        = target;
`endif

  always_comb begin
    pc_nxt  = pc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (en) begin
      case (op_q)
        PC_OP_SEQ: pc_nxt = seq_pc;
        PC_OP_JUMP: pc_nxt = tgt;
        PC_OP_CALL: begin
          // Call still jumps when the stack is full; only the push is lost.
          pc_nxt  = tgt;
          push    = ~stack_full;
          err_set = stack_full;
        end
        PC_OP_RET: begin
          // Return with nothing stacked falls through to the next instruction.
          if (stack_empty) begin
            pc_nxt  = seq_pc;
            err_set = 1'b1;
          end else begin
            pc_nxt = stk_top;
            pop    = 1'b1;
          end
        end
        default: pc_nxt = seq_pc;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= '0;
      err <= 1'b0;
    end else begin
      pc  <= pc_nxt;
      err <= err | err_set;
    end
  end

  pc_ret_stack #(
    .WIDTH      (WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_ret_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(seq_pc),
    .pop      (pop),
    .top      (stk_top),
    .full     (stack_full),
    .empty    (stack_empty)
  );

endmodule

// File: tb/tb_pc_call_stack.sv
// Directed bench for pc_call_stack (WIDTH=32, LAST=16, STEP=1, STACK_DEPTH=4).
// Each step pushes the expected post-edge state from a queue-based model; the
// state is popped and compared one time unit after the rising edge.
module tb_pc_call_stack;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] target = '0;
  logic        rel = 1'b0;
  logic [31:0] pc;
  logic        stack_full;
  logic        stack_empty;
  logic        err;

  pc_call_stack #(
    .WIDTH      (32),
    .LAST       (16),
    .STEP       (1),
    .STACK_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .op         (op),
    .target     (target),
    .rel        (rel),
    .pc         (pc),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        empty;
    logic        full;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  string       tag_q[$];

  logic [31:0] m_pc;
  logic [31:0] m_stk[$];
  logic        m_err;

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] seq_f(input logic [31:0] p);
    return (p < 32'd16) ? (p + 32'd1) : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = '0;
    m_err = 1'b0;
    m_stk.delete();
  endtask

  task automatic compare_next();
    exp_t  e;
    string t;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: no expected entry queued");
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check({t, "_pc"}, pc, e.pc);
      check({t, "_empty"}, {31'd0, stack_empty}, {31'd0, e.empty});
      check({t, "_full"}, {31'd0, stack_full}, {31'd0, e.full});
      check({t, "_err"}, {31'd0, err}, {31'd0, e.err});
    end
  endtask

  // Drive one cycle of stimulus, predict the result, compare after the edge.
  task automatic step(input logic e, input logic [1:0] o, input logic [31:0] t,
                      input logic r, input string tag);
    logic [31:0] tg;
    exp_t        x;
    @(negedge clk);
    en = e; op = o; target = t; rel = r;
`ifdef PC_REL_BRANCH_EN
    tg = r ? (m_pc + t) : t;
`else
    tg = t;
`endif
    if (e) begin
      case (o)
        2'b00: m_pc = seq_f(m_pc);
        2'b01: m_pc = tg;
        2'b10: begin
          if (m_stk.size() < 4) m_stk.push_back(seq_f(m_pc));
          else m_err = 1'b1;
          m_pc = tg;
        end
        default: begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin
            m_pc  = seq_f(m_pc);
            m_err = 1'b1;
          end
        end
      endcase
    end
    x.pc    = m_pc;
    x.empty = (m_stk.size() == 0);
    x.full  = (m_stk.size() == 4);
    x.err   = m_err;
    sb_q.push_back(x);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    compare_next();
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    model_reset();
    #2;
    check("rst_pc", pc, 32'd0);
    check("rst_empty", {31'd0, stack_empty}, 32'd1);
    check("rst_full", {31'd0, stack_full}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1. Sequential fetch with wrap after LAST
    for (int i = 0; i < 20; i++) step(1'b1, PC_OP_SEQ, 32'd0, 1'b0, "t1_seq");
    check("t1_final_pc", pc, 32'd3);
    check("t1_err", {31'd0, err}, 32'd0);

    // 2. Absolute jump
    step(1'b1, PC_OP_JUMP, 32'd5, 1'b0, "t2_to5");
    step(1'b1, PC_OP_JUMP, 32'h40, 1'b0, "t2_jump");
    check("t2_pc", pc, 32'h40);
    check("t2_empty", {31'd0, stack_empty}, 32'd1);

    // 3. Call then return
    step(1'b1, PC_OP_JUMP, 32'd3, 1'b0, "t3_to3");
    step(1'b1, PC_OP_CALL, 32'h20, 1'b0, "t3_call");
    check("t3_call_pc", pc, 32'h20);
    check("t3_call_empty", {31'd0, stack_empty}, 32'd0);
    step(1'b1, PC_OP_RET, 32'd0, 1'b0, "t3_ret");
    check("t3_ret_pc", pc, 32'd4);
    check("t3_ret_empty", {31'd0, stack_empty}, 32'd1);

    // 4. Overflow and underflow (pc=4: returns 11,8,3,5 then seq(5)=6)
    step(1'b1, PC_OP_CALL, 32'd2, 1'b0, "t4_call1");
    step(1'b1, PC_OP_CALL, 32'd7, 1'b0, "t4_call2");
    step(1'b1, PC_OP_CALL, 32'd10, 1'b0, "t4_call3");
    step(1'b1, PC_OP_CALL, 32'd13, 1'b0, "t4_call4");
    check("t4_full", {31'd0, stack_full}, 32'd1);
    check("t4_err_before", {31'd0, err}, 32'd0);
    step(1'b1, PC_OP_CALL, 32'd15, 1'b0, "t4_call5");
    check("t4_pc5", pc, 32'd15);
    check("t4_err_after", {31'd0, err}, 32'd1);
    step(1'b1, PC_OP_RET, 32'd0, 1'b0, "t4_ret1");
    check("t4_ret1_pc", pc, 32'd11);
    step(1'b1, PC_OP_RET, 32'd0, 1'b0, "t4_ret2");
    check("t4_ret2_pc", pc, 32'd8);
    step(1'b1, PC_OP_RET, 32'd0, 1'b0, "t4_ret3");
    check("t4_ret3_pc", pc, 32'd3);
    step(1'b1, PC_OP_RET, 32'd0, 1'b0, "t4_ret4");
    check("t4_ret4_pc", pc, 32'd5);
    step(1'b1, PC_OP_RET, 32'd0, 1'b0, "t4_ret5");
    check("t4_ret5_pc", pc, 32'd6);

    // 5. Stall with CALL on the inputs, then asynchronous reset mid-cycle
    step(1'b1, PC_OP_CALL, 32'd9, 1'b0, "t5_call");
    for (int i = 0; i < 3; i++) step(1'b0, PC_OP_CALL, 32'h77, 1'b0, "t5_stall");
    check("t5_stall_pc", pc, 32'd9);
    check("t5_stall_empty", {31'd0, stack_empty}, 32'd0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("t5_rst_pc", pc, 32'd0);
    check("t5_rst_empty", {31'd0, stack_empty}, 32'd1);
    check("t5_rst_full", {31'd0, stack_full}, 32'd0);
    check("t5_rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, PC_OP_RET, 32'd0, 1'b0, "t5_ret_after_rst");

    // 6. Relative-target behaviour (build dependent)
    step(1'b1, PC_OP_JUMP, 32'h10, 1'b0, "t6_to10");
    step(1'b1, PC_OP_JUMP, 32'hFFFF_FFFC, 1'b1, "t6_rel");
`ifdef PC_REL_BRANCH_EN
    check("t6_pc", pc, 32'h0000_000C);
`else
    check("t6_pc", pc, 32'hFFFF_FFFC);
`endif
    step(1'b1, PC_OP_SEQ, 32'd0, 1'b0, "t6_seq_wrap");

    @(negedge clk);
    en = 1'b0;
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
